// File: rtl/ip_stream_pkg.sv
// Shared types and constants for the ip_send_recv load sequencer.
package ip_stream_pkg;

    localparam int KEY_BYTES    = 16;
    localparam int ADDR_ENTRIES = 8;
    localparam int ADDR_BYTES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY,
        ST_ADDR,
        ST_STREAM
    } state_t;

    // sel 0 picks the most significant byte, matching the wire order.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ip_addr_table.sv
// 8 x 32-bit IPv4 address table: synchronous write, combinational read,
// cleared by rst so unwritten entries read as zero.
module ip_addr_table
    import ip_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_idx,
    input  logic [31:0] i_wr_data,
    input  logic [2:0]  i_rd_idx,
    output logic [31:0] o_rd_data
);

    logic [31:0] r_mem [ADDR_ENTRIES];

    // NOTE: this storage is reset on purpose (never-written entries must read
    // zero), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ADDR_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/ip_stream_loader.sv
// Serializes key, address table and paced packet bytes into the byte-wide
// load interface of ip_send_recv.
module ip_stream_loader #(
    parameter int KEY_BYTES    = ip_stream_pkg::KEY_BYTES,
    parameter int ADDR_ENTRIES = ip_stream_pkg::ADDR_ENTRIES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_start,
    input  logic [127:0] key_in,
    input  logic         addr_wr,
    input  logic [2:0]   addr_idx,
    input  logic [31:0]  addr_data,
    input  logic [7:0]   pkt_in,
    input  logic         pkt_valid,
    output logic         pkt_ready,
    output logic [7:0]   ld_byte,
    output logic         key_enable,
    output logic         address_enable,
    output logic         ready,
    input  logic         busy,
    output logic         cfg_done
);

    localparam logic [3:0] KEY_LAST  = 4'(KEY_BYTES - 1);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_ENTRIES * ip_stream_pkg::ADDR_BYTES - 1);

    ip_stream_pkg::state_t r_state, w_state_nxt;

    logic [3:0]   r_key_cnt,  w_key_cnt_nxt;
    logic [4:0]   r_addr_cnt, w_addr_cnt_nxt;
    logic [127:0] r_key_sh,   w_key_sh_nxt;
    logic [7:0]   r_ld_byte,  w_ld_byte_nxt;
    logic         r_key_en,   w_key_en_nxt;
    logic         r_addr_en,  w_addr_en_nxt;
    logic         r_ready,    w_ready_nxt;
    logic         r_cfg_done, w_cfg_done_nxt;

    logic         w_open;
    logic         w_cfg_accept;
    logic         w_pkt_fire;
    logic         w_tbl_wr;
    logic [4:0]   w_addr_cnt_inc;
    logic [2:0]   w_rd_idx;
    logic [1:0]   w_rd_sel;
    logic [31:0]  w_rd_data;
    logic [7:0]   w_tbl_byte;

    // Configuration inputs are only honoured while nothing is being serialized.
    assign w_open       = (r_state == ip_stream_pkg::ST_IDLE) || (r_state == ip_stream_pkg::ST_STREAM);
    assign w_cfg_accept = cfg_start && w_open;
    assign w_tbl_wr     = addr_wr && w_open;

    assign pkt_ready  = (r_state == ip_stream_pkg::ST_STREAM) && !busy && !cfg_start;
    assign w_pkt_fire = pkt_valid && pkt_ready;

    // Look one byte ahead: the table byte read now is the one presented next cycle.
    assign w_addr_cnt_inc = r_addr_cnt + 5'd1;
    assign w_rd_idx       = (r_state == ip_stream_pkg::ST_ADDR) ? w_addr_cnt_inc[4:2] : 3'd0;
    assign w_rd_sel       = (r_state == ip_stream_pkg::ST_ADDR) ? w_addr_cnt_inc[1:0] : 2'd0;
    assign w_tbl_byte     = ip_stream_pkg::word_byte(w_rd_data, w_rd_sel);

    ip_addr_table u_table (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_tbl_wr),
        .i_wr_idx  (addr_idx),
        .i_wr_data (addr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // NOTE: every signal gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_key_cnt_nxt  = r_key_cnt;
        w_addr_cnt_nxt = r_addr_cnt;
        w_key_sh_nxt   = r_key_sh;
        w_ld_byte_nxt  = r_ld_byte;
        w_key_en_nxt   = 1'b0;
        w_addr_en_nxt  = 1'b0;
        w_ready_nxt    = 1'b0;

        if (w_cfg_accept) begin
            w_state_nxt   = ip_stream_pkg::ST_KEY;
            w_key_cnt_nxt = 4'd0;
            w_key_sh_nxt  = {key_in[119:0], 8'h00};
            w_ld_byte_nxt = key_in[127:120];
            w_key_en_nxt  = 1'b1;
        end else begin
            case (r_state)
                ip_stream_pkg::ST_KEY: begin
                    if (r_key_cnt == KEY_LAST) begin
                        w_state_nxt    = ip_stream_pkg::ST_ADDR;
                        w_addr_cnt_nxt = 5'd0;
                        w_ld_byte_nxt  = w_tbl_byte;
                        w_addr_en_nxt  = 1'b1;
                    end else begin
                        w_key_cnt_nxt = r_key_cnt + 4'd1;
                        w_ld_byte_nxt = r_key_sh[127:120];
                        w_key_sh_nxt  = {r_key_sh[119:0], 8'h00};
                        w_key_en_nxt  = 1'b1;
                    end
                end
                ip_stream_pkg::ST_ADDR: begin
                    if (r_addr_cnt == ADDR_LAST) begin
                        w_state_nxt = ip_stream_pkg::ST_STREAM;
                    end else begin
                        w_addr_cnt_nxt = w_addr_cnt_inc;
                        w_ld_byte_nxt  = w_tbl_byte;
                        w_addr_en_nxt  = 1'b1;
                    end
                end
                ip_stream_pkg::ST_STREAM: begin
                    if (w_pkt_fire) begin
                        w_ld_byte_nxt = pkt_in;
                        w_ready_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        w_cfg_done_nxt = (w_state_nxt == ip_stream_pkg::ST_STREAM);
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ip_stream_pkg::ST_IDLE;
            r_key_cnt  <= '0;
            r_addr_cnt <= '0;
            r_key_sh   <= '0;
            r_ld_byte  <= '0;
            r_key_en   <= 1'b0;
            r_addr_en  <= 1'b0;
            r_ready    <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_cnt  <= w_key_cnt_nxt;
            r_addr_cnt <= w_addr_cnt_nxt;
            r_key_sh   <= w_key_sh_nxt;
            r_ld_byte  <= w_ld_byte_nxt;
            r_key_en   <= w_key_en_nxt;
            r_addr_en  <= w_addr_en_nxt;
            r_ready    <= w_ready_nxt;
            r_cfg_done <= w_cfg_done_nxt;
        end
    end

    assign ld_byte        = r_ld_byte;
    assign key_enable     = r_key_en;
    assign address_enable = r_addr_en;
    assign ready          = r_ready;
    assign cfg_done       = r_cfg_done;

endmodule

// File: tb/tb_ip_stream_loader.sv
// Scoreboard bench for ip_stream_loader: a transaction-level model queues the
// expected byte stream, a negedge monitor pops and compares.
module tb_ip_stream_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_start;
    logic [127:0] key_in;
    logic         addr_wr;
    logic [2:0]   addr_idx;
    logic [31:0]  addr_data;
    logic [7:0]   pkt_in;
    logic         pkt_valid;
    logic         busy;
    logic         pkt_ready;
    logic [7:0]   ld_byte;
    logic         key_enable;
    logic         address_enable;
    logic         ready;
    logic         cfg_done;

    always #5 clk = ~clk;

    ip_stream_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .key_in         (key_in),
        .addr_wr        (addr_wr),
        .addr_idx       (addr_idx),
        .addr_data      (addr_data),
        .pkt_in         (pkt_in),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .ld_byte        (ld_byte),
        .key_enable     (key_enable),
        .address_enable (address_enable),
        .ready          (ready),
        .busy           (busy),
        .cfg_done       (cfg_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a load is "48 bytes go out back to back", a stream
    // byte is "what was handed over goes out next cycle".
    typedef enum {M_IDLE, M_LOAD, M_STREAM} mmode_t;
    localparam logic [1:0] K_KEY = 2'd0, K_ADDR = 2'd1, K_PKT = 2'd2;

    mmode_t      m_mode = M_IDLE;
    int          m_load_left = 0;
    logic [31:0] m_table [8];
    logic [9:0]  m_q [$];
    logic        m_exp_ready = 1'b0;
    logic [7:0]  m_last = 8'h00;
    bit          m_live = 1'b0;
    bit          m_acc = 1'b0;

    task automatic model_edge();
        mmode_t pre;
        m_live      = 1'b1;
        m_exp_ready = 1'b0;
        m_acc       = 1'b0;
        if (rst) begin
            m_mode      = M_IDLE;
            m_load_left = 0;
            m_last      = 8'h00;
            m_q.delete();
            for (int i = 0; i < 8; i++) m_table[i] = 32'h0;
            return;
        end
        pre = m_mode;
        if (pre == M_STREAM && pkt_valid && !busy && !cfg_start) begin
            m_q.push_back({K_PKT, pkt_in});
            m_exp_ready = 1'b1;
            m_acc       = 1'b1;
        end
        if (addr_wr && pre != M_LOAD) m_table[addr_idx] = addr_data;
        if (pre == M_LOAD) begin
            m_load_left--;
            if (m_load_left == 0) m_mode = M_STREAM;
        end
        if (cfg_start && pre != M_LOAD) begin
            for (int i = 0; i < 16; i++) m_q.push_back({K_KEY, key_in[127 - 8*i -: 8]});
            for (int e = 0; e < 8; e++)
                for (int b = 0; b < 4; b++) m_q.push_back({K_ADDR, m_table[e][31 - 8*b -: 8]});
            m_mode      = M_LOAD;
            m_load_left = 48;
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            logic [9:0] exp_item;
            logic [1:0] kind;
            check("one_hot", 32'($countones({key_enable, address_enable, ready}) <= 1), 32'd1);
            check("cfg_done", cfg_done, m_mode == M_STREAM);
            check("pkt_ready", pkt_ready, (m_mode == M_STREAM) && !busy && !cfg_start);
            check("ready", ready, m_exp_ready);
            if (m_mode == M_LOAD) check("load_enable", key_enable | address_enable, 1'b1);
            if (key_enable || address_enable || ready) begin
                kind = key_enable ? K_KEY : (address_enable ? K_ADDR : K_PKT);
                if (m_q.size() == 0) begin
                    check("sb_extra_byte", m_q.size(), 32'd1);
                end else begin
                    exp_item = m_q.pop_front();
                    check("sb_byte", {kind, ld_byte}, exp_item);
                    m_last = exp_item[7:0];
                end
            end else begin
                check("ld_hold", ld_byte, m_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [7:0] pkt_bytes [4];

    initial begin
        int idx, cyc;
        rst = 1'b1; cfg_start = 1'b0; key_in = '0; addr_wr = 1'b0; addr_idx = '0;
        addr_data = '0; pkt_in = '0; pkt_valid = 1'b0; busy = 1'b0;
        pkt_bytes[0] = 8'h61; pkt_bytes[1] = 8'hca; pkt_bytes[2] = 8'h9b; pkt_bytes[3] = 8'hbf;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed key/table load.
        addr_wr = 1'b1; addr_idx = 3'd0; addr_data = 32'ha761ca9b; tick();
        addr_idx = 3'd4; addr_data = 32'h43c97381; tick();
        addr_wr = 1'b0;
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        repeat (52) tick();

        // Stream with busy pacing.
        idx = 0; cyc = 0; pkt_valid = 1'b1;
        while (idx < 4 && cyc < 50) begin
            pkt_in = pkt_bytes[idx];
            busy = (cyc >= 2 && cyc <= 5);
            tick();
            if (m_acc) idx++;
            cyc++;
        end
        check("stream_handover", idx, 4);
        pkt_valid = 1'b0; busy = 1'b0;
        repeat (3) tick();

        // cfg_start and addr_wr during KEY byte 7 are ignored.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        repeat (7) tick();
        cfg_start = 1'b1; addr_wr = 1'b1; addr_idx = 3'd2; addr_data = $urandom;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        cfg_start = 1'b0; addr_wr = 1'b0;
        repeat (50) tick();

        // Reset during ADDR byte 10, then a fresh load from a cleared table.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        repeat (26) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        key_in = {$urandom, $urandom, $urandom, $urandom};
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        repeat (52) tick();

        // cfg_start in STREAM against a pending packet.
        pkt_valid = 1'b1; pkt_in = 8'($urandom);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        repeat (60) begin
            pkt_in = 8'($urandom);
            tick();
        end

        // Randomized traffic.
        repeat (600) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_start = ($urandom_range(0, 59) == 0);
            addr_wr   = ($urandom_range(0, 3) == 0);
            addr_idx  = 3'($urandom);
            addr_data = $urandom;
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            busy      = ($urandom_range(0, 2) == 0);
            pkt_valid = ($urandom_range(0, 2) != 0);
            pkt_in    = 8'($urandom);
            tick();
        end

        rst = 1'b0; cfg_start = 1'b0; addr_wr = 1'b0; pkt_valid = 1'b0; busy = 1'b0;
        cyc = 0;
        while (m_q.size() > 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        @(negedge clk); #1;
        check("drain", m_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ip_stream_loader.md
# ip_stream_loader

Upstream feeder for `ip_send_recv`. Takes a 128-bit AES key, an 8-entry table of 32-bit IPv4 addresses and a byte-wide packet stream. Serializes them into the byte-wide load interface of `ip_send_recv`: key first, then the address table, then packet bytes paced by `busy`. Replaces the bench-side sequencing with synthesizable RTL, so the encryption core runs from a MAC/FIFO source.

## Interface
Parameters:
- `KEY_BYTES`, 16, key length in bytes; the design supports only 16.
- `ADDR_ENTRIES`, 8, number of 32-bit address table entries.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse; captures `key_in` and starts the key/address load.
- `key_in` in 128: AES key, sampled on an accepted `cfg_start`.
- `addr_wr` in 1: address table write strobe.
- `addr_idx` in 3: address table write index.
- `addr_data` in 32: address table write data.
- `pkt_in` in 8: packet byte.
- `pkt_valid` in 1: `pkt_in` is valid.
- `pkt_ready` out 1: loader accepts `pkt_in` this cycle.
- `ld_byte` out 8: byte to `ip_send_recv` `in`.
- `key_enable` out 1: `ld_byte` is a key byte.
- `address_enable` out 1: `ld_byte` is an address byte.
- `ready` out 1: `ld_byte` is a packet byte.
- `busy` in 1: from `ip_send_recv`; high means no packet byte may be presented.
- `cfg_done` out 1: high while in STREAM.

## Operation
- States:
  - IDLE: after reset.
  - KEY: `KEY_BYTES` cycles.
  - ADDR: `4*ADDR_ENTRIES` cycles.
  - STREAM: packet bytes.
- IDLE→KEY on `cfg_start`. The key shift register is loaded with `key_in`.
- KEY: one byte per cycle, MSB byte (`key[127:120]`) first, with `key_enable`=1. After byte 15 the FSM moves to ADDR.
- ADDR: entries in order 0..7. Each entry goes MSB byte first, one byte per cycle, with `address_enable`=1. After byte 31 the FSM moves to STREAM.
- STREAM:
  - `pkt_ready` = STREAM && !`busy` (combinational).
  - On `pkt_valid`&&`pkt_ready`, the next cycle has `ld_byte`=`pkt_in` and `ready`=1. Otherwise `ready`=0.
- `cfg_start` is accepted in IDLE and STREAM; accepted in STREAM it re-enters KEY. It is ignored in KEY and ADDR.
- Address table:
  - `addr_wr` is honoured only in IDLE and STREAM. Writes in KEY/ADDR are dropped so the table is stable while it is serialized.
  - Entries never written read as 0x00000000.
  - The table is cleared by `rst`.
- When `key_enable`, `address_enable` and `ready` are all low, `ld_byte` holds its last value.
- At most one of `key_enable`, `address_enable`, `ready` is high in any cycle.

## Timing
- Reset values:
  - `ld_byte`=0x00, `key_enable`=0, `address_enable`=0, `ready`=0, `cfg_done`=0.
  - `pkt_ready`=0, because state is IDLE.
  - Table all zero.
- All outputs except `pkt_ready` are registered.
- Latency:
  - `cfg_start` at cycle N → first key byte on `ld_byte` at N+1.
  - Last key byte at N+16.
  - First address byte at N+17, last at N+48.
  - `cfg_done`=1 from N+49.
- Packet accepted at cycle M → `ready` pulse at M+1. Throughput is 1 byte/cycle while `busy`=0.
- `busy` rising at cycle M blocks acceptance at M. A byte accepted at M−1 is still presented at M. `ip_send_recv` must absorb this one in-flight byte.
- A `cfg_start` that coincides with a packet handshake in STREAM takes priority: the packet is not accepted (`pkt_ready` forced 0 that cycle), and KEY starts next cycle.
- `rst` mid-KEY or mid-ADDR: the next cycle is IDLE with all outputs at reset values; the partial load is abandoned.
- Same-cycle `addr_wr` and `cfg_start` in IDLE: the write takes effect. ADDR starts 16 cycles later and sends the new value.

## Structure
- Package `ip_stream_pkg`:
  - State enum (IDLE/KEY/ADDR/STREAM).
  - `KEY_BYTES`, `ADDR_ENTRIES`, `ADDR_BYTES`=4.
- Sub-module `ip_addr_table`: 8×32 register file, synchronous write with enable, combinational read by index, synchronous clear on `rst`.
- Top level: FSM, 4-bit key byte counter, 5-bit address byte counter (entry = cnt[4:2], byte = cnt[1:0]), 128-bit key shift register, output registers.

## Test plan
- Load key 0x000102030405060708090a0b0c0d0e0f, pulse `cfg_start` → `ld_byte` 00,01,…,0f on 16 consecutive cycles with `key_enable`=1, then `address_enable` rises.
- Write idx0=0xa761ca9b, idx4=0x43c97381, others unwritten → ADDR bytes 0–3 = a7,61,ca,9b; bytes 16–19 = 43,c9,73,81; all other bytes 00; `cfg_done`=1 after byte 31.
- STREAM with `pkt_valid`=1 and bytes 61,ca,9b,bf, `busy` high for cycles 2–5 → `pkt_ready`=0 while `busy`=1. `ready` pulses carry 61,ca,9b,bf in order with no loss or duplication.
- `cfg_start` and `addr_wr` asserted at KEY byte 7 → ignored; byte sequence continues to 0f; table unchanged.
- `rst` at ADDR byte 10 → next cycle all enables 0, `ld_byte`=00, `cfg_done`=0, table cleared; a fresh `cfg_start` restarts from key byte 0.
- `cfg_start` in STREAM with `pkt_valid`=1 → no packet accepted that cycle; full 48-byte reload with the new `key_in`, then streaming resumes.
